jk_driver: RTL

JK_DRIVER -- requirements
Module: jk_driver

---
 rtl/jk_pkg.sv | 32 +++
 rtl/jk_drv_fifo.sv | 54 +++++
 rtl/jk_driver.sv | 136 +++++++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// Shared types and JK encodings for the JK flip-flop excitation driver.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  typedef struct packed {
    logic       tbit;
    logic [3:0] len;
  } entry_t;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  function automatic logic jk_next(input logic q, input logic [1:0] jk);
    logic r;
    r = q;
    unique case (jk)
      JK_HOLD: r = q;
      JK_RST:  r = 1'b0;
      JK_SET:  r = 1'b1;
      JK_TGL:  r = ~q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_drv_fifo.sv
// Target-entry FIFO for jk_driver; pointers wrap naturally at power-of-two DEPTH.
module jk_drv_fifo
  import jk_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t pop_data,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/jk_driver.sv
// Drives j/k of a downstream JK flop through queued target states with hold times.
// Define JK_FB_CHECK_EN to add q_fb/err_clr inputs and a sticky fb_err output.
module jk_driver
  import jk_pkg::*;
#(
  parameter int   DEPTH  = 4,
  parameter logic DC_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tgt_valid,
  output logic       tgt_ready,
  input  logic       tgt_bit,
  input  logic [3:0] tgt_len,
  output logic       j,
  output logic       k,
  output logic       q_model,
  output logic       busy,
  output logic       done
`ifdef JK_FB_CHECK_EN
  ,
  input  logic       q_fb,
  input  logic       err_clr,
  output logic       fb_err
`endif
);

  state_e     state_q, state_d;
  entry_t     cur_q, cur_d;
  entry_t     head, in_ent;
  logic [3:0] cnt_q, cnt_d;
  logic       q_model_q, q_model_d;
  logic       push, pop, full, empty, fin;

  assign in_ent    = '{tbit: tgt_bit, len: tgt_len};
  assign push      = tgt_valid && !full;
  assign tgt_ready = !full;
  assign q_model   = q_model_q;
  assign busy      = (state_q != IDLE) || !empty;

  jk_drv_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(in_ent),
    .pop      (pop),
    .pop_data (head),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    done    = 1'b0;
    fin     = 1'b0;
    j       = 1'b0;
    k       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cur_d   = head;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        unique case ({q_model_q, cur_q.tbit})
          2'b00: begin j = 1'b0;   k = DC_VAL; end
          2'b01: begin j = 1'b1;   k = DC_VAL; end
          2'b10: begin j = DC_VAL; k = 1'b1;   end
          2'b11: begin j = DC_VAL; k = 1'b0;   end
        endcase
        if (cur_q.len != 4'd0) begin
          state_d = HOLD;
          cnt_d   = cur_q.len;
        end else begin
          fin = 1'b1;
        end
      end
      HOLD: begin
        cnt_d = cnt_q - 4'd1;
        fin   = (cnt_q == 4'd1);
      end
      default: state_d = IDLE;
    endcase
    // Last cycle of an entry chains straight into the next one.
    if (fin) begin
      done = 1'b1;
      if (!empty) begin
        pop     = 1'b1;
        cur_d   = head;
        state_d = DRIVE;
      end else begin
        state_d = IDLE;
      end
    end
    q_model_d = jk_next(q_model_q, {j, k});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      cnt_q     <= '0;
      q_model_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      q_model_q <= q_model_d;
    end
  end

`ifdef JK_FB_CHECK_EN
  logic fb_err_q, fb_err_d;

  assign fb_err = fb_err_q;

  always_comb begin
    fb_err_d = fb_err_q;
    if (err_clr)              fb_err_d = 1'b0;
    if (q_fb != q_model_q)    fb_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fb_err_q <= 1'b0;
    else        fb_err_q <= fb_err_d;
  end
`endif

endmodule
